dmg_link_peer: RTL and testbench

- Behavioural model of the far end of the DMG serial link cable.
- Exchanges one 8-bit byte per transfer with the DMG serial port.
- Acts as clock slave, following the SCK driven by the DMG, or as clock master, generating SCK for a DMG set to external clock.
- Sits in the SoC testbench/top next to the serial pins; used for link-port verification and for emulated two-player setups.

---
 rtl/dmg_link_peer.sv | 169 ++++++++++++++++
 tb/tb_dmg_link_peer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmg_link_peer.sv
// Far end of the DMG serial link cable: exchanges one byte per transfer,
// either following the DMG's SCK (slave) or generating SCK itself (master).
`timescale 1ns/1ps
module dmg_link_peer #(
  parameter int unsigned CLK_DIV = 256
) (
  input  logic       clk,
  input  logic       res,
  input  logic       mode_master,
  input  logic       start,
  input  logic       tx_load,
  input  logic [7:0] tx_data,
  input  logic       sck_in,
  output logic       sck_out,
  output logic       sck_oe,
  input  logic       sin,
  output logic       sout,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SLAVE_XFER, MASTER_LOW, MASTER_HIGH} state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] div_q, div_d;
  logic        rx_valid_q, rx_valid_d;
  logic        busy_q, busy_d;
  logic        sck_out_q, sck_out_d;
  logic        sck_oe_q, sck_oe_d;
  logic        sout_q, sout_d;
  logic        sck_s1_q, sck_s2_q, sck_prev_q;
  logic        sin_s1_q, sin_s2_q;

  logic       sck_fall, sck_rise, div_done, first_bit;
  logic [7:0] shifted;

  assign sck_fall  = sck_prev_q & ~sck_s2_q;
  assign sck_rise  = ~sck_prev_q & sck_s2_q;
  assign div_done  = (div_q == DIV_LAST);
  assign first_bit = tx_load ? tx_data[7] : shreg_q[7];
  assign shifted   = {shreg_q[6:0], sin_s2_q};

  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= IDLE;
      shreg_q    <= 8'hFF;
      rx_data_q  <= 8'h00;
      bit_cnt_q  <= 4'd0;
      div_q      <= 16'd0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      sck_out_q  <= 1'b1;
      sck_oe_q   <= 1'b0;
      sout_q     <= 1'b1;
      sck_s1_q   <= 1'b1;
      sck_s2_q   <= 1'b1;
      sck_prev_q <= 1'b1;
      sin_s1_q   <= 1'b1;
      sin_s2_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      div_q      <= div_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      sck_out_q  <= sck_out_d;
      sck_oe_q   <= sck_oe_d;
      sout_q     <= sout_d;
      sck_s1_q   <= sck_in;
      sck_s2_q   <= sck_s1_q;
      sck_prev_q <= sck_s2_q;
      sin_s1_q   <= sin;
      sin_s2_q   <= sin_s1_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    div_d      = div_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    sck_out_d  = sck_out_q;
    sck_oe_d   = sck_oe_q;
    sout_d     = sout_q;
    case (state_q)
      IDLE: begin
        if (tx_load) shreg_d = tx_data;
        if (mode_master && start) begin
          sck_oe_d  = 1'b1;
          sck_out_d = 1'b0;
          sout_d    = first_bit;
          busy_d    = 1'b1;
          bit_cnt_d = 4'd0;
          div_d     = 16'd0;
          state_d   = MASTER_LOW;
        end else if (!mode_master && sck_fall) begin
          sout_d    = first_bit;
          busy_d    = 1'b1;
          bit_cnt_d = 4'd0;
          state_d   = SLAVE_XFER;
        end
      end
      SLAVE_XFER: begin
        if (sck_fall) begin
          sout_d = shreg_q[7];
        end else if (sck_rise) begin
          shreg_d   = shifted;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            rx_data_d  = shifted;
            rx_valid_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      MASTER_LOW: begin
        if (div_done) begin
          div_d     = 16'd0;
          sck_out_d = 1'b1;
          shreg_d   = shifted;
          bit_cnt_d = bit_cnt_q + 4'd1;
          state_d   = MASTER_HIGH;
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      MASTER_HIGH: begin
        // The last high phase is held in full so a transfer spans 16 half-periods.
        if (div_done) begin
          div_d = 16'd0;
          if (bit_cnt_q == 4'd8) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
            sck_oe_d   = 1'b0;
            busy_d     = 1'b0;
            state_d    = IDLE;
          end else begin
            sck_out_d = 1'b0;
            sout_d    = shreg_q[7];
            state_d   = MASTER_LOW;
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sck_out  = sck_out_q;
  assign sck_oe   = sck_oe_q;
  assign sout     = sout_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_dmg_link_peer.sv
// Randomised bench for dmg_link_peer: a DMG model drives the cable side and a
// byte-exchange model predicts what each transfer sends and receives.
`timescale 1ns/1ps
module tb_dmg_link_peer;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       mode_master = 1'b0;
  logic       start = 1'b0;
  logic       tx_load = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       sck_in = 1'b1;
  logic       sin = 1'b1;
  logic       sck_out, sck_oe, sout, rx_valid, busy;
  logic [7:0] rx_data;

  int total = 0;
  int bad = 0;
  int rx_pulses = 0;
  logic [7:0] last_rx = 8'h00;
  logic [7:0] model_shreg = 8'hFF;

  dmg_link_peer #(.CLK_DIV(DIV)) dut (
    .clk(clk), .res(res), .mode_master(mode_master), .start(start),
    .tx_load(tx_load), .tx_data(tx_data), .sck_in(sck_in), .sck_out(sck_out),
    .sck_oe(sck_oe), .sin(sin), .sout(sout), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_pulses <= rx_pulses + 1;
      last_rx   <= rx_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] b);
    tx_data = b;
    tx_load = 1'b1;
    tick();
    tx_load = 1'b0;
  endtask

  // DMG on internal clock: falls SCK, puts its bit on sin, samples sout before rising.
  task automatic dmg_slave(input logic [7:0] dmg_byte, input int nbits, input int half,
                           output logic [7:0] peer_byte);
    peer_byte = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      sck_in = 1'b0;
      sin    = dmg_byte[7-i];
      repeat (half) tick();
      peer_byte = {peer_byte[6:0], sout};
      sck_in = 1'b1;
      repeat (half) tick();
    end
    repeat (4) tick();
  endtask

  // DMG on external clock: follows sck_out, observing cycle k after the start edge.
  task automatic run_master(input logic [7:0] dmg_byte, input bit load, input logic [7:0] txb,
                            input bit same_cycle, input bit disturb,
                            output logic [7:0] peer_byte, output int lows, output int low_bad,
                            output int oe_cycles, output int rxv_k, output logic oe_at_rxv,
                            output int pulses);
    int p0, run, bitidx;
    logic prev;
    mode_master = 1'b1;
    if (load && !same_cycle) load_byte(txb);
    p0 = rx_pulses;
    start = 1'b1;
    if (load && same_cycle) begin
      tx_data = txb;
      tx_load = 1'b1;
    end
    tick();
    start = 1'b0;
    tx_load = 1'b0;
    peer_byte = 8'h00; lows = 0; low_bad = 0; oe_cycles = 0; rxv_k = -1;
    oe_at_rxv = 1'bx; run = 0; bitidx = 0; prev = 1'b1;
    for (int k = 0; k < 16*DIV + 12; k++) begin
      if (sck_oe === 1'b1) oe_cycles++;
      if (rx_valid === 1'b1 && rxv_k < 0) begin
        rxv_k = k;
        oe_at_rxv = sck_oe;
      end
      if (sck_out === 1'b0) begin
        if (prev) begin
          lows++;
          if (bitidx < 8) sin = dmg_byte[7-bitidx];
          bitidx++;
        end
        run++;
      end else if (!prev) begin
        peer_byte = {peer_byte[6:0], sout};
        if (run != DIV) low_bad++;
        run = 0;
      end
      prev = sck_out;
      if (disturb && k == 20) begin
        start = 1'b1;
        tx_load = 1'b1;
        tx_data = 8'h00;
      end
      tick();
      if (disturb && k == 20) begin
        start = 1'b0;
        tx_load = 1'b0;
      end
    end
    pulses = rx_pulses - p0;
    mode_master = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b1;
    repeat (3) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (sout !== 1'b1) begin bad++; $display("FAIL reset_sout got=%0b want=1", sout); end
    total++; if (sck_out !== 1'b1) begin bad++; $display("FAIL reset_sck_out got=%0b want=1", sck_out); end
    total++; if (sck_oe !== 1'b0) begin bad++; $display("FAIL reset_sck_oe got=%0b want=0", sck_oe); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%0b want=0", rx_valid); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%0h want=00", rx_data); end
    res = 1'b0;
    tick();
    model_shreg = 8'hFF;
    $display("reset: busy=%0b sout=%0b sck_oe=%0b", busy, sout, sck_oe);
  endtask

  task automatic test_slave_basic();
    logic [7:0] pb;
    int p0;
    mode_master = 1'b0;
    load_byte(8'hA5);
    model_shreg = 8'hA5;
    p0 = rx_pulses;
    dmg_slave(8'h3C, 8, 8, pb);
    total++; if (pb !== model_shreg) begin bad++; $display("FAIL slave_sent got=%0h want=%0h", pb, model_shreg); end
    total++; if (last_rx !== 8'h3C) begin bad++; $display("FAIL slave_rx got=%0h want=3c", last_rx); end
    total++; if (rx_pulses - p0 != 1) begin bad++; $display("FAIL slave_pulses got=%0d want=1", rx_pulses - p0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL slave_busy_after got=%0b want=0", busy); end
    total++; if (sck_oe !== 1'b0) begin bad++; $display("FAIL slave_sck_oe got=%0b want=0", sck_oe); end
    model_shreg = 8'h3C;
    $display("slave xfer: sent=%0h recv=%0h", pb, last_rx);
  endtask

  task automatic test_slave_random();
    logic [7:0] pb, dmg_b, txb;
    int p0, half;
    mode_master = 1'b0;
    for (int n = 0; n < 6; n++) begin
      dmg_b = 8'($urandom);
      half  = $urandom_range(4, 10);
      if (n > 0 && $urandom_range(0, 1) == 1) begin
        txb = 8'($urandom);
        load_byte(txb);
        model_shreg = txb;
      end
      p0 = rx_pulses;
      dmg_slave(dmg_b, 8, half, pb);
      total++; if (pb !== model_shreg) begin bad++; $display("FAIL rnd_slave_sent[%0d] got=%0h want=%0h", n, pb, model_shreg); end
      total++; if (last_rx !== dmg_b || rx_pulses - p0 != 1) begin
        bad++; $display("FAIL rnd_slave_rx[%0d] got=%0h/%0d want=%0h/1", n, last_rx, rx_pulses - p0, dmg_b);
      end
      model_shreg = dmg_b;
      $display("slave xfer: half=%0d sent=%0h recv=%0h", half, pb, last_rx);
    end
  endtask

  task automatic test_master();
    logic [7:0] pb;
    int lows, low_bad, oe_cycles, rxv_k, pulses;
    logic oe_at;
    run_master(8'hF0, 1'b1, 8'h81, 1'b0, 1'b0, pb, lows, low_bad, oe_cycles, rxv_k, oe_at, pulses);
    total++; if (lows != 8) begin bad++; $display("FAIL master_lows got=%0d want=8", lows); end
    total++; if (low_bad != 0) begin bad++; $display("FAIL master_low_len bad_pulses=%0d want=0", low_bad); end
    total++; if (oe_cycles != 16*DIV) begin bad++; $display("FAIL master_oe_cycles got=%0d want=%0d", oe_cycles, 16*DIV); end
    total++; if (rxv_k != 16*DIV) begin bad++; $display("FAIL master_rxv_cycle got=%0d want=%0d", rxv_k, 16*DIV); end
    total++; if (oe_at !== 1'b0) begin bad++; $display("FAIL master_oe_at_rxv got=%0b want=0", oe_at); end
    total++; if (pb !== 8'h81) begin bad++; $display("FAIL master_sent got=%0h want=81", pb); end
    total++; if (last_rx !== 8'hF0 || pulses != 1) begin bad++; $display("FAIL master_rx got=%0h/%0d want=f0/1", last_rx, pulses); end
    model_shreg = 8'hF0;
    $display("master xfer: sent=%0h recv=%0h rxv_cycle=%0d", pb, last_rx, rxv_k);
  endtask

  task automatic test_same_cycle_load();
    logic [7:0] pb, dmg_b;
    int lows, low_bad, oe_cycles, rxv_k, pulses;
    logic oe_at;
    dmg_b = 8'($urandom);
    run_master(dmg_b, 1'b1, 8'h55, 1'b1, 1'b0, pb, lows, low_bad, oe_cycles, rxv_k, oe_at, pulses);
    total++; if (pb[7] !== 1'b0) begin bad++; $display("FAIL same_cycle_first_bit got=%0b want=0", pb[7]); end
    total++; if (pb !== 8'h55) begin bad++; $display("FAIL same_cycle_sent got=%0h want=55", pb); end
    total++; if (last_rx !== dmg_b) begin bad++; $display("FAIL same_cycle_rx got=%0h want=%0h", last_rx, dmg_b); end
    model_shreg = dmg_b;
    $display("master xfer: sent=%0h recv=%0h", pb, last_rx);
  endtask

  task automatic test_back_to_back();
    logic [7:0] pb, dmg_b, txb;
    int lows, low_bad, oe_cycles, rxv_k, pulses;
    logic oe_at;
    for (int n = 0; n < 3; n++) begin
      dmg_b = 8'($urandom);
      txb   = 8'($urandom);
      if (n == 1) begin
        run_master(dmg_b, 1'b0, txb, 1'b0, 1'b0, pb, lows, low_bad, oe_cycles, rxv_k, oe_at, pulses);
      end else begin
        run_master(dmg_b, 1'b1, txb, 1'b0, 1'b0, pb, lows, low_bad, oe_cycles, rxv_k, oe_at, pulses);
        model_shreg = txb;
      end
      total++; if (pb !== model_shreg) begin bad++; $display("FAIL b2b_sent[%0d] got=%0h want=%0h", n, pb, model_shreg); end
      total++; if (last_rx !== dmg_b || pulses != 1) begin
        bad++; $display("FAIL b2b_rx[%0d] got=%0h/%0d want=%0h/1", n, last_rx, pulses, dmg_b);
      end
      model_shreg = dmg_b;
      $display("master xfer: sent=%0h recv=%0h", pb, last_rx);
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] pb, dmg_b;
    int lows, low_bad, oe_cycles, rxv_k, pulses;
    logic oe_at;
    dmg_b = 8'($urandom);
    run_master(dmg_b, 1'b1, 8'hC6, 1'b0, 1'b1, pb, lows, low_bad, oe_cycles, rxv_k, oe_at, pulses);
    total++; if (pb !== 8'hC6) begin bad++; $display("FAIL busy_ignore_sent got=%0h want=c6", pb); end
    total++; if (pulses != 1) begin bad++; $display("FAIL busy_ignore_pulses got=%0d want=1", pulses); end
    total++; if (oe_cycles != 16*DIV || lows != 8) begin
      bad++; $display("FAIL busy_ignore_second_xfer oe=%0d lows=%0d want=%0d/8", oe_cycles, lows, 16*DIV);
    end
    model_shreg = dmg_b;
    $display("master xfer (disturbed): sent=%0h recv=%0h", pb, last_rx);
  endtask

  task automatic test_reset_mid();
    logic [7:0] pb;
    int p0;
    mode_master = 1'b0;
    load_byte(8'h00);
    dmg_slave(8'hC3, 3, 6, pb);
    res = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%0b want=0", busy); end
    total++; if (sout !== 1'b1) begin bad++; $display("FAIL midreset_sout got=%0b want=1", sout); end
    total++; if (sck_oe !== 1'b0) begin bad++; $display("FAIL midreset_sck_oe got=%0b want=0", sck_oe); end
    res = 1'b0;
    tick();
    model_shreg = 8'hFF;
    p0 = rx_pulses;
    dmg_slave(8'h12, 8, 6, pb);
    total++; if (pb !== model_shreg) begin bad++; $display("FAIL midreset_sent got=%0h want=%0h", pb, model_shreg); end
    total++; if (last_rx !== 8'h12 || rx_pulses - p0 != 1) begin
      bad++; $display("FAIL midreset_rx got=%0h/%0d want=12/1", last_rx, rx_pulses - p0);
    end
    model_shreg = 8'h12;
    $display("slave xfer after reset: sent=%0h recv=%0h", pb, last_rx);
  endtask

  task automatic test_slave_start_ignored();
    logic [7:0] pb, dmg_b;
    int oe_seen, busy_seen, p0;
    mode_master = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    oe_seen = 0; busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (sck_oe !== 1'b0) oe_seen++;
      if (busy !== 1'b0) busy_seen++;
      tick();
    end
    total++; if (oe_seen != 0) begin bad++; $display("FAIL slave_start_oe cycles=%0d want=0", oe_seen); end
    total++; if (busy_seen != 0) begin bad++; $display("FAIL slave_start_busy cycles=%0d want=0", busy_seen); end
    dmg_b = 8'($urandom);
    p0 = rx_pulses;
    dmg_slave(dmg_b, 8, 5, pb);
    total++; if (pb !== model_shreg) begin bad++; $display("FAIL slave_start_sent got=%0h want=%0h", pb, model_shreg); end
    total++; if (last_rx !== dmg_b || rx_pulses - p0 != 1) begin
      bad++; $display("FAIL slave_start_rx got=%0h/%0d want=%0h/1", last_rx, rx_pulses - p0, dmg_b);
    end
    model_shreg = dmg_b;
    $display("slave xfer after ignored start: sent=%0h recv=%0h", pb, last_rx);
  endtask

  initial begin
    test_reset();
    test_slave_basic();
    test_slave_random();
    test_master();
    test_same_cycle_load();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_slave_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
